fetch_replay_queue: RTL and testbench

Parametrised instruction replay queue between fetch and decode. Fetch keeps delivering instructions for FETCH_LAT cycles after decode stalls. This block captures those in-flight instructions during a stall of any length, replays them in order when the stall releases, and then returns to zero-latency bypass. It also tells fetch to hold before storage can overflow, and supports flush on redirect.

---
 rtl/frq_pkg.sv | 17 +
 rtl/frq_storage.sv | 25 ++
 rtl/fetch_replay_queue.sv | 108 ++++++++++
 tb/tb_fetch_replay_queue.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/frq_pkg.sv
// rtl/frq_pkg.sv - shared types and width helpers for the fetch replay queue
package frq_pkg;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_REPLAY = 1'b1
    } mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/frq_storage.sv
// rtl/frq_storage.sv - entry array, one write port and one asynchronous read port
module frq_storage #(
    parameter int DEPTH = 8,
    parameter int EW    = 32,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [EW-1:0]    wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [EW-1:0]    rd_data
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_replay_queue.sv
// rtl/fetch_replay_queue.sv - captures in-flight fetches during a decode stall and replays them in order
module fetch_replay_queue
    import frq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PC_W      = 16,
    parameter int DEPTH     = 8,
    parameter int FETCH_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_instr,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic                       fetch_hold,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int EW    = WIDTH + PC_W;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push_req, push, pop, full;
    mode_e            mode;
    entry_t           head, incoming;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign mode     = (count == '0) ? MODE_BYPASS : MODE_REPLAY;
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = out_ready && (mode == MODE_REPLAY) && !flush;
    // Once anything is queued, later arrivals must queue behind it to keep order.
    assign push_req = in_valid && !flush && ((mode == MODE_REPLAY) || !out_ready);
    assign push     = push_req && (!full || pop);
    assign incoming = '{pc: in_pc, instr: in_instr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (push_req && !push) begin
                overflow_err <= 1'b1;
            end
        end
    end

    frq_storage #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (incoming),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    always_comb begin
        out_valid = 1'b0;
        out_instr = incoming.instr;
        out_pc    = incoming.pc;
        if (mode == MODE_REPLAY) begin
            out_instr = head.instr;
            out_pc    = head.pc;
        end
        if (rst_n && !flush) begin
            out_valid = (mode == MODE_REPLAY) || in_valid;
        end
    end

    // Registered-count only, so fetch sees no combinational path from the handshake.
    assign fetch_hold = (count >= CNT_W'(DEPTH - FETCH_LAT));

endmodule

// File: tb/tb_fetch_replay_queue.sv
// tb/tb_fetch_replay_queue.sv - randomized and directed check of two queue depths against a queue model
module tb_fetch_replay_queue;

    typedef logic [31:0] q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        out_ready;

    logic        a_valid, a_hold, a_ovf;
    logic [15:0] a_instr, a_pc;
    logic [3:0]  a_count;
    logic        b_valid, b_hold, b_ovf;
    logic [15:0] b_instr, b_pc;
    logic [2:0]  b_count;

    q_t qa, qb;
    bit ova, ovb;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_replay_queue #(.WIDTH(16), .PC_W(16), .DEPTH(8), .FETCH_LAT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .out_ready(out_ready),
        .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc),
        .fetch_hold(a_hold), .count(a_count), .overflow_err(a_ovf)
    );

    fetch_replay_queue #(.WIDTH(16), .PC_W(16), .DEPTH(5), .FETCH_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .out_ready(out_ready),
        .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc),
        .fetch_hold(b_hold), .count(b_count), .overflow_err(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input q_t q, input int d, input bit ovf,
                             input logic v, input logic [15:0] ins, input logic [15:0] pc,
                             input logic h, input logic [3:0] cnt, input logic oe);
        logic        ev;
        logic [31:0] e;
        ev = rst_n && !flush && (q.size() > 0 || in_valid);
        chk({nm, ".out_valid"}, 32'(v), 32'(ev));
        if (ev) begin
            e = (q.size() > 0) ? q[0] : {in_pc, in_instr};
            chk({nm, ".out_instr"}, 32'(ins), 32'(e[15:0]));
            chk({nm, ".out_pc"}, 32'(pc), 32'(e[31:16]));
        end
        chk({nm, ".fetch_hold"}, 32'(h), 32'(q.size() >= d - 3));
        chk({nm, ".count"}, 32'(cnt), 32'(q.size()));
        chk({nm, ".overflow_err"}, 32'(oe), 32'(ovf));
    endtask

    task automatic model_step(input q_t q, input int d, input bit ovf, output q_t qn, output bit ovfn);
        int sz;
        bit popped;
        sz     = q.size();
        qn     = q;
        ovfn   = ovf;
        popped = 1'b0;
        if (flush) begin
            qn.delete();
        end else begin
            if (out_ready && sz > 0) begin
                void'(qn.pop_front());
                popped = 1'b1;
            end
            if (in_valid && (sz > 0 || !out_ready)) begin
                if (sz < d || popped) qn.push_back({in_pc, in_instr});
                else ovfn = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [15:0] ins, input bit rdy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = 16'($urandom);
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        check_dut("a", qa, 8, ova, a_valid, a_instr, a_pc, a_hold, a_count, a_ovf);
        check_dut("b", qb, 5, ovb, b_valid, b_instr, b_pc, b_hold, 4'(b_count), b_ovf);
        @(posedge clk);
        model_step(qa, 8, ova, qa, ova);
        model_step(qb, 5, ovb, qb, ovb);
        #1;
    endtask

    task automatic async_reset();
        #2;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst.a_count", 32'(a_count), 32'd0);
        chk("rst.a_valid", 32'(a_valid), 32'd0);
        chk("rst.b_count", 32'(b_count), 32'd0);
        chk("rst.b_valid", 32'(b_valid), 32'd0);
        chk("rst.a_ovf", 32'(a_ovf), 32'd0);
        chk("rst.a_hold", 32'(a_hold), 32'd0);
        qa.delete();
        qb.delete();
        ova = 1'b0;
        ovb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        async_reset();

        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h1000 + i), 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'hA0 + i), 1'b0, 1'b0);
        chk("stall.a_count_peak", 32'(a_count), 32'd4);
        for (int i = 4; i < 12; i++) cyc(1'b1, 16'(16'hA0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) cyc(1'b1, 16'(16'hD0 + i), 1'b0, 1'b0);
        chk("ovf.a_count_full", 32'(a_count), 32'd8);
        chk("ovf.a_sticky", 32'(a_ovf), 32'd1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ovf.a_still_set", 32'(a_ovf), 32'd1);

        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'hE0 + i), 1'b0, 1'b0);
        async_reset();

        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'hF0 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b1);
        cyc(1'b1, 16'h1234, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) cyc(1'b1, 16'(16'hC0 + i), 1'((i % 2) != 0), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
